// File: rtl/csc_pixel_scheduler.sv
// ---------------------------------------------------------------------------
// csc_pixel_scheduler
//
// Walks a frame stored in SRAM through the colourspace converter. For each
// pixel pair k it reads one Y, one U and one V word (two 8-bit samples per
// word), runs the converter once per pixel (high bytes first, then low
// bytes), and packs the two 24-bit RGB results into three 16-bit words that
// are written back starting at RGB_BASE + 3k.
//
// Ports
//   Clock            in   1   system clock, posedge only
//   Reset            in   1   synchronous, active-high
//   start            in   1   begin a frame; only looked at while idle
//   SRAM_grant       in   1   SRAM port grant (only with CSC_SRAM_GRANT_EN)
//   busy             out  1   frame in progress
//   done             out  1   one-cycle pulse after the last RGB write
//   SRAM_address     out  18  word address
//   SRAM_write_data  out  16  write data
//   SRAM_we_n        out  1   active-low write enable
//   SRAM_read_data   in   16  read data, SRAM_RD_LAT cycles after address
//   conv_Y/U/V       out  8   converter operands, stable for a conversion
//   conv_start       out  1   one-cycle converter start pulse
//   conv_RGB         in   24  converter result {R,G,B}
//
// Optional feature
//   CSC_SRAM_GRANT_EN : adds SRAM_grant. SRAM accesses (read issue and write)
//                       only happen, and only advance, on granted cycles.
//                       Without it the grant is a constant 1.
// ---------------------------------------------------------------------------
module csc_pixel_scheduler #(
    parameter logic [17:0] Y_BASE      = 18'd0,
    parameter logic [17:0] U_BASE      = 18'd38400,
    parameter logic [17:0] V_BASE      = 18'd57600,
    parameter logic [17:0] RGB_BASE    = 18'd146944,
    parameter logic [17:0] NUM_PAIRS   = 18'd19200,
    parameter int unsigned CONV_LAT    = 5,
    parameter int unsigned SRAM_RD_LAT = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        start,
`ifdef CSC_SRAM_GRANT_EN
    input  logic        SRAM_grant,
`endif
    output logic        busy,
    output logic        done,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic [7:0]  conv_Y,
    output logic [7:0]  conv_U,
    output logic [7:0]  conv_V,
    output logic        conv_start,
    input  logic [23:0] conv_RGB
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_CONV0,
        S_CONV1,
        S_WR,
        S_NEXT,
        S_DONE
    } state_t;

    // Last value of the per-state cycle counter in each timed state.
    localparam logic [7:0] ACC_LAST  = 8'd2;
    localparam logic [7:0] WAIT_LAST = 8'(SRAM_RD_LAT - 1);
    localparam logic [7:0] CONV_LAST = 8'(CONV_LAT);

    logic grant;
`ifdef CSC_SRAM_GRANT_EN
    assign grant = SRAM_grant;
`else
    assign grant = 1'b1;
`endif

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [17:0] k, k_n;
    logic [17:0] wr_base, wr_base_n;   // RGB_BASE + 3k, kept as a running sum

    logic [15:0] y_word, u_word, v_word;
    logic [23:0] rgb0, rgb1;

    // Read-return tracking: one entry per cycle of SRAM latency. Each entry
    // remembers whether a read was actually issued and which word it was.
    logic       rd_vld [SRAM_RD_LAT];
    logic [1:0] rd_sel [SRAM_RD_LAT];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            k       <= '0;
            wr_base <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            k       <= k_n;
            wr_base <= wr_base_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        k_n       = k;
        wr_base_n = wr_base;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n   = S_RD_ISSUE;
                    cnt_n     = '0;
                    k_n       = '0;
                    wr_base_n = RGB_BASE;
                end
            end
            S_RD_ISSUE: begin
                // An ungranted cycle repeats the same read.
                if (grant) begin
                    if (cnt == ACC_LAST) begin
                        state_n = S_RD_WAIT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            S_RD_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    state_n = S_CONV0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_CONV0: begin
                if (cnt == CONV_LAST) begin
                    state_n = S_CONV1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_CONV1: begin
                if (cnt == CONV_LAST) begin
                    state_n = S_WR;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            S_WR: begin
                // An ungranted cycle repeats the same write.
                if (grant) begin
                    if (cnt == ACC_LAST) begin
                        state_n = S_NEXT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            S_NEXT: begin
                cnt_n = '0;
                if (k == NUM_PAIRS - 18'd1) begin
                    state_n = S_DONE;
                end else begin
                    state_n   = S_RD_ISSUE;
                    k_n       = k + 18'd1;
                    wr_base_n = wr_base + 18'd3;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registered state)
    // ------------------------------------------------------------------
    always_comb begin
        busy            = (state != S_IDLE) && (state != S_DONE);
        done            = (state == S_DONE);
        SRAM_address    = '0;
        SRAM_write_data = '0;
        // Reset gates the strobe so a write cannot land on the reset cycle.
        SRAM_we_n       = !((state == S_WR) && grant && !Reset);
        conv_start      = ((state == S_CONV0) || (state == S_CONV1)) && (cnt == '0);
        conv_Y          = '0;
        conv_U          = '0;
        conv_V          = '0;

        case (state)
            S_RD_ISSUE: begin
                case (cnt[1:0])
                    2'd0:    SRAM_address = Y_BASE + k;
                    2'd1:    SRAM_address = U_BASE + k;
                    default: SRAM_address = V_BASE + k;
                endcase
            end
            S_WR: begin
                SRAM_address = wr_base + {16'd0, cnt[1:0]};
                case (cnt[1:0])
                    2'd0:    SRAM_write_data = {rgb0[23:16], rgb0[15:8]};
                    2'd1:    SRAM_write_data = {rgb0[7:0],   rgb1[23:16]};
                    default: SRAM_write_data = {rgb1[15:8],  rgb1[7:0]};
                endcase
            end
            S_CONV0: begin
                conv_Y = y_word[15:8];
                conv_U = u_word[15:8];
                conv_V = v_word[15:8];
            end
            S_CONV1: begin
                conv_Y = y_word[7:0];
                conv_U = u_word[7:0];
                conv_V = v_word[7:0];
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: read-return capture and converter result capture
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int unsigned i = 0; i < SRAM_RD_LAT; i++) begin
                rd_vld[i] <= 1'b0;
                rd_sel[i] <= '0;
            end
            y_word <= '0;
            u_word <= '0;
            v_word <= '0;
            rgb0   <= '0;
            rgb1   <= '0;
        end else begin
            rd_vld[0] <= (state == S_RD_ISSUE) && grant;
            rd_sel[0] <= cnt[1:0];
            for (int unsigned i = 1; i < SRAM_RD_LAT; i++) begin
                rd_vld[i] <= rd_vld[i-1];
                rd_sel[i] <= rd_sel[i-1];
            end

            if (rd_vld[SRAM_RD_LAT-1]) begin
                case (rd_sel[SRAM_RD_LAT-1])
                    2'd0:    y_word <= SRAM_read_data;
                    2'd1:    u_word <= SRAM_read_data;
                    default: v_word <= SRAM_read_data;
                endcase
            end

            if ((state == S_CONV0) && (cnt == CONV_LAST)) rgb0 <= conv_RGB;
            if ((state == S_CONV1) && (cnt == CONV_LAST)) rgb1 <= conv_RGB;
        end
    end

endmodule

// File: tb/tb_csc_pixel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_csc_pixel_scheduler
//
// Two schedulers share one clock and reset: instance 0 runs single-pair
// frames, instance 1 runs three-pair frames. Each has its own SRAM read
// model (fixed two-cycle latency) and converter model (five-cycle latency,
// result valid for exactly one cycle). Expected reads and writes are queued
// when a frame is set up and consumed as the scheduler drives the SRAM.
// ---------------------------------------------------------------------------
module tb_csc_pixel_scheduler;

    localparam logic [17:0] Y_BASE   = 18'd0;
    localparam logic [17:0] U_BASE   = 18'd38400;
    localparam logic [17:0] V_BASE   = 18'd57600;
    localparam logic [17:0] RGB_BASE = 18'd146944;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Reset;
    logic        start   [2];
    logic        grant   [2];
    logic        busy    [2];
    logic        done    [2];
    logic        we_n    [2];
    logic        cstart  [2];
    logic [17:0] addr    [2];
    logic [15:0] wdata   [2];
    logic [15:0] rdata   [2];
    logic [7:0]  cy      [2];
    logic [7:0]  cu      [2];
    logic [7:0]  cv      [2];
    logic [23:0] crgb    [2];

    int checks   = 0;
    int failures = 0;

    csc_pixel_scheduler #(
        .Y_BASE(Y_BASE), .U_BASE(U_BASE), .V_BASE(V_BASE), .RGB_BASE(RGB_BASE),
        .NUM_PAIRS(18'd1), .CONV_LAT(5), .SRAM_RD_LAT(2)
    ) dut0 (
        .Clock(clk), .Reset(Reset), .start(start[0]),
`ifdef CSC_SRAM_GRANT_EN
        .SRAM_grant(grant[0]),
`endif
        .busy(busy[0]), .done(done[0]), .SRAM_address(addr[0]),
        .SRAM_write_data(wdata[0]), .SRAM_we_n(we_n[0]), .SRAM_read_data(rdata[0]),
        .conv_Y(cy[0]), .conv_U(cu[0]), .conv_V(cv[0]), .conv_start(cstart[0]),
        .conv_RGB(crgb[0])
    );

    csc_pixel_scheduler #(
        .Y_BASE(Y_BASE), .U_BASE(U_BASE), .V_BASE(V_BASE), .RGB_BASE(RGB_BASE),
        .NUM_PAIRS(18'd3), .CONV_LAT(5), .SRAM_RD_LAT(2)
    ) dut1 (
        .Clock(clk), .Reset(Reset), .start(start[1]),
`ifdef CSC_SRAM_GRANT_EN
        .SRAM_grant(grant[1]),
`endif
        .busy(busy[1]), .done(done[1]), .SRAM_address(addr[1]),
        .SRAM_write_data(wdata[1]), .SRAM_we_n(we_n[1]), .SRAM_read_data(rdata[1]),
        .conv_Y(cy[1]), .conv_U(cu[1]), .conv_V(cv[1]), .conv_start(cstart[1]),
        .conv_RGB(crgb[1])
    );

    // ---------------- frame contents and reference converter -------------
    logic [15:0] py [3];
    logic [15:0] pu [3];
    logic [15:0] pv [3];

    function automatic logic [15:0] mem_rd(input logic [17:0] a);
        if (a - Y_BASE < 3) return py[int'(a - Y_BASE)];
        if (a - U_BASE < 3) return pu[int'(a - U_BASE)];
        if (a - V_BASE < 3) return pv[int'(a - V_BASE)];
        return 16'hBAD0;
    endfunction

    function automatic logic [7:0] clip8(input int x);
        if (x < 0)   return 8'd0;
        if (x > 255) return 8'd255;
        return 8'(x);
    endfunction

    // BT.601 studio-range YUV to RGB, 8.8 fixed point.
    function automatic logic [23:0] conv(input logic [7:0] y, input logic [7:0] u,
                                         input logic [7:0] v);
        int c, d, e;
        c = int'(y) - 16;
        d = int'(u) - 128;
        e = int'(v) - 128;
        return {clip8((298*c + 409*e + 128) >>> 8),
                clip8((298*c - 100*d - 208*e + 128) >>> 8),
                clip8((298*c + 516*d + 128) >>> 8)};
    endfunction

    // ---------------- SRAM and converter models --------------------------
    logic [15:0] rp [2][2];
    logic [23:0] cp [2][5];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            rp[i][0] <= mem_rd(addr[i]);
            rp[i][1] <= rp[i][0];
            cp[i][0] <= cstart[i] ? conv(cy[i], cu[i], cv[i]) : 24'h5A5A5A;
            for (int j = 1; j < 5; j++) cp[i][j] <= cp[i][j-1];
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rdata[i] = rp[i][1];
            crgb[i]  = cp[i][4];
        end
    end

    // ---------------- scoreboard -----------------------------------------
    logic [33:0] exp_wr0 [$];
    logic [33:0] exp_wr1 [$];
    logic [17:0] exp_rd0 [$];
    logic [17:0] exp_rd1 [$];

    int          wr_seen  [2];
    int          busy_cnt [2];
    int          bc       [2];
    int          done_cnt [2];
    int          cs_cnt   [2];
    logic [15:0] wd_or    [2];
    logic [15:0] wd_and   [2];
    bit          rd_chk = 1'b1;

    task automatic clear_counters();
        for (int i = 0; i < 2; i++) begin
            wr_seen[i]  = 0;
            busy_cnt[i] = 0;
            done_cnt[i] = 0;
            cs_cnt[i]   = 0;
            wd_or[i]    = 16'h0000;
            wd_and[i]   = 16'hFFFF;
        end
    endtask

    task automatic clear_queues();
        exp_wr0.delete();
        exp_wr1.delete();
        exp_rd0.delete();
        exp_rd1.delete();
    endtask

    task automatic push_frame(input int idx, input int npairs);
        logic [23:0] r0, r1;
        logic [17:0] wa;
        for (int k = 0; k < npairs; k++) begin
            r0 = conv(py[k][15:8], pu[k][15:8], pv[k][15:8]);
            r1 = conv(py[k][7:0],  pu[k][7:0],  pv[k][7:0]);
            wa = RGB_BASE + 18'(3*k);
            if (idx == 0) begin
                exp_rd0.push_back(Y_BASE + 18'(k));
                exp_rd0.push_back(U_BASE + 18'(k));
                exp_rd0.push_back(V_BASE + 18'(k));
                exp_wr0.push_back({wa,          r0[23:16], r0[15:8]});
                exp_wr0.push_back({wa + 18'd1,  r0[7:0],   r1[23:16]});
                exp_wr0.push_back({wa + 18'd2,  r1[15:8],  r1[7:0]});
            end else begin
                exp_rd1.push_back(Y_BASE + 18'(k));
                exp_rd1.push_back(U_BASE + 18'(k));
                exp_rd1.push_back(V_BASE + 18'(k));
                exp_wr1.push_back({wa,          r0[23:16], r0[15:8]});
                exp_wr1.push_back({wa + 18'd1,  r0[7:0],   r1[23:16]});
                exp_wr1.push_back({wa + 18'd2,  r1[15:8],  r1[7:0]});
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [33:0] ew;
        logic [17:0] er;
        bit          have;
        for (int i = 0; i < 2; i++) begin
            if (we_n[i] === 1'b0) begin
                wr_seen[i]++;
                wd_or[i]  = wd_or[i] | wdata[i];
                wd_and[i] = wd_and[i] & wdata[i];
                have = (i == 0) ? (exp_wr0.size() != 0) : (exp_wr1.size() != 0);
                checks++;
                if (!have) begin
                    failures++;
                    $display("FAIL wr%0d: unexpected write addr=%h data=%h, none expected",
                             i, addr[i], wdata[i]);
                end else begin
                    if (i == 0) ew = exp_wr0.pop_front();
                    else        ew = exp_wr1.pop_front();
                    if ({addr[i], wdata[i]} !== ew) begin
                        failures++;
                        $display("FAIL wr%0d: got addr=%h data=%h, expected addr=%h data=%h",
                                 i, addr[i], wdata[i], ew[33:16], ew[15:0]);
                    end
                end
            end
            if (busy[i] === 1'b1) begin
                busy_cnt[i]++;
                if (rd_chk && (bc[i] % 21) < 3) begin
                    have = (i == 0) ? (exp_rd0.size() != 0) : (exp_rd1.size() != 0);
                    checks++;
                    if (!have) begin
                        failures++;
                        $display("FAIL rd%0d: unexpected read addr=%h, none expected", i, addr[i]);
                    end else begin
                        if (i == 0) er = exp_rd0.pop_front();
                        else        er = exp_rd1.pop_front();
                        if (addr[i] !== er || we_n[i] !== 1'b1) begin
                            failures++;
                            $display("FAIL rd%0d: got addr=%h we_n=%b, expected addr=%h we_n=1",
                                     i, addr[i], we_n[i], er);
                        end
                    end
                end
                bc[i]++;
            end else begin
                bc[i] = 0;
            end
            if (done[i] === 1'b1)   done_cnt[i]++;
            if (cstart[i] === 1'b1) cs_cnt[i]++;
`ifdef CSC_SRAM_GRANT_EN
            if (grant[i] === 1'b0 && busy[i] === 1'b1) begin
                checks++;
                if (we_n[i] !== 1'b1) begin
                    failures++;
                    $display("FAIL grant%0d: we_n=%b while ungranted, expected 1", i, we_n[i]);
                end
            end
`endif
        end
    end

    // Pulses start, waits (bounded) for done, returns the cycle index of done
    // (cycle 1 = first cycle after start was sampled), or 0 on timeout.
    task automatic run_frame(input int idx, input int restart_at, input int g_lo,
                             input int g_hi, output int n);
        @(negedge clk);
        start[idx] = 1'b1;
        @(negedge clk);
        start[idx] = 1'b0;
        n = 1;
        while (done[idx] !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            start[idx] = (n + 1 == restart_at);
            grant[idx] = !((n + 1 >= g_lo) && (n + 1 <= g_hi));
            @(negedge clk);
            n++;
        end
        start[idx] = 1'b0;
        grant[idx] = 1'b1;
        if (done[idx] !== 1'b1) n = 0;
        repeat (30) @(negedge clk);
        #1;
    endtask

    // ---------------- tests ----------------------------------------------
    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({busy[i], done[i], we_n[i], cstart[i]} !== 4'b0010) begin
                failures++;
                $display("FAIL reset_ctrl%0d: busy/done/we_n/conv_start=%b, expected 0010",
                         i, {busy[i], done[i], we_n[i], cstart[i]});
            end
            checks++;
            if ({addr[i], wdata[i]} !== 34'd0) begin
                failures++;
                $display("FAIL reset_bus%0d: addr=%h data=%h, expected 0 0", i, addr[i], wdata[i]);
            end
            checks++;
            if ({cy[i], cu[i], cv[i]} !== 24'd0) begin
                failures++;
                $display("FAIL reset_conv%0d: YUV=%h, expected 000000", i, {cy[i], cu[i], cv[i]});
            end
        end
        Reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_start: busy=%b%b, expected 00", busy[0], busy[1]);
        end
    endtask

    task automatic test_black();
        int n;
        py[0] = 16'h1010; pu[0] = 16'h8080; pv[0] = 16'h8080;
        clear_counters();
        push_frame(0, 1);
        run_frame(0, 0, 0, -1, n);
        checks++;
        if (n !== 22) begin
            failures++;
            $display("FAIL black_done_cycle: done at cycle %0d, expected 22", n);
        end
        checks++;
        if (busy_cnt[0] !== 21) begin
            failures++;
            $display("FAIL black_busy: busy for %0d cycles, expected 21", busy_cnt[0]);
        end
        checks++;
        if (wr_seen[0] !== 3 || wd_or[0] !== 16'h0000) begin
            failures++;
            $display("FAIL black_writes: %0d writes OR=%h, expected 3 writes of 0000",
                     wr_seen[0], wd_or[0]);
        end
        checks++;
        if (exp_wr0.size() != 0 || exp_rd0.size() != 0 || done_cnt[0] !== 1) begin
            failures++;
            $display("FAIL black_complete: pending wr=%0d rd=%0d done=%0d, expected 0 0 1",
                     exp_wr0.size(), exp_rd0.size(), done_cnt[0]);
        end
    endtask

    task automatic test_white();
        int n;
        py[0] = 16'hEBEB; pu[0] = 16'h8080; pv[0] = 16'h8080;
        clear_counters();
        push_frame(0, 1);
        run_frame(0, 0, 0, -1, n);
        checks++;
        if (wr_seen[0] !== 3 || wd_and[0] !== 16'hFFFF) begin
            failures++;
            $display("FAIL white_writes: %0d writes AND=%h, expected 3 writes of FFFF",
                     wr_seen[0], wd_and[0]);
        end
        checks++;
        if (cs_cnt[0] !== 2) begin
            failures++;
            $display("FAIL white_conv_start: %0d pulses, expected 2", cs_cnt[0]);
        end
        checks++;
        if (n !== 22 || exp_wr0.size() != 0) begin
            failures++;
            $display("FAIL white_frame: done at %0d pending wr=%0d, expected 22 0",
                     n, exp_wr0.size());
        end
    endtask

    task automatic test_three_pairs();
        int n;
        py[0] = 16'h1010; pu[0] = 16'h8080; pv[0] = 16'h8080;
        py[1] = 16'hEB60; pu[1] = 16'h80C0; pv[1] = 16'h8030;
        py[2] = 16'h8050; pu[2] = 16'h4090; pv[2] = 16'hA060;
        clear_counters();
        push_frame(1, 3);
        run_frame(1, 0, 0, -1, n);
        checks++;
        if (busy_cnt[1] !== 63) begin
            failures++;
            $display("FAIL three_busy: busy for %0d cycles, expected 63", busy_cnt[1]);
        end
        checks++;
        if (n !== 64) begin
            failures++;
            $display("FAIL three_done_cycle: done at cycle %0d, expected 64", n);
        end
        checks++;
        if (wr_seen[1] !== 9 || exp_wr1.size() != 0 || exp_rd1.size() != 0) begin
            failures++;
            $display("FAIL three_traffic: %0d writes pending wr=%0d rd=%0d, expected 9 0 0",
                     wr_seen[1], exp_wr1.size(), exp_rd1.size());
        end
        checks++;
        if (cs_cnt[1] !== 6 || done_cnt[1] !== 1) begin
            failures++;
            $display("FAIL three_pulses: conv_start=%0d done=%0d, expected 6 1",
                     cs_cnt[1], done_cnt[1]);
        end
    endtask

    task automatic test_start_ignored();
        int n;
        py[0] = 16'h6090; pu[0] = 16'hA050; pv[0] = 16'h70B0;
        clear_counters();
        push_frame(0, 1);
        run_frame(0, 10, 0, -1, n);
        checks++;
        if (done_cnt[0] !== 1 || n !== 22) begin
            failures++;
            $display("FAIL restart_ignored: done pulses=%0d at cycle %0d, expected 1 at 22",
                     done_cnt[0], n);
        end
        checks++;
        if (wr_seen[0] !== 3 || exp_wr0.size() != 0 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL restart_traffic: %0d writes pending=%0d busy=%b, expected 3 0 0",
                     wr_seen[0], exp_wr0.size(), busy[0]);
        end
    endtask

    task automatic test_reset_mid_wr();
        int n;
        py[0] = 16'h3040; pu[0] = 16'h9070; pv[0] = 16'h60A0;
        py[1] = 16'hC020; pu[1] = 16'h8080; pv[1] = 16'hF010;
        py[2] = 16'h5555; pu[2] = 16'hAAAA; pv[2] = 16'h2288;
        clear_counters();
        push_frame(1, 3);
        @(negedge clk);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        n = 0;
        while (wr_seen[1] == 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (wr_seen[1] == 0) begin
            failures++;
            $display("FAIL abort_reach_wr: no write within %0d cycles, expected one", n);
        end
        // Second write cycle of the pair: reset lands here.
        @(posedge clk);
        #1;
        Reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (we_n[1] !== 1'b1 || busy[1] !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: we_n=%b busy=%b, expected 1 0", we_n[1], busy[1]);
        end
        Reset = 1'b0;
        checks++;
        if (wr_seen[1] !== 1 || exp_wr1.size() != 8) begin
            failures++;
            $display("FAIL abort_writes: %0d writes pending=%0d, expected 1 8",
                     wr_seen[1], exp_wr1.size());
        end
        clear_queues();
        clear_counters();
        push_frame(1, 3);
        run_frame(1, 0, 0, -1, n);
        checks++;
        if (n !== 64 || wr_seen[1] !== 9 || exp_wr1.size() != 0 || exp_rd1.size() != 0) begin
            failures++;
            $display("FAIL abort_rerun: done at %0d, %0d writes, pending wr=%0d rd=%0d, expected 64 9 0 0",
                     n, wr_seen[1], exp_wr1.size(), exp_rd1.size());
        end
    endtask

`ifdef CSC_SRAM_GRANT_EN
    task automatic test_grant();
        int n;
        py[0] = 16'h9A40; pu[0] = 16'h70C0; pv[0] = 16'hB050;
        clear_counters();
        clear_queues();
        rd_chk = 1'b0;
        push_frame(0, 1);
        // Writes occupy cycles 18..20 ungated; withhold grant on 19..22.
        run_frame(0, 0, 19, 22, n);
        rd_chk = 1'b1;
        checks++;
        if (n !== 26) begin
            failures++;
            $display("FAIL grant_frame: done at cycle %0d, expected 26", n);
        end
        checks++;
        if (wr_seen[0] !== 3 || exp_wr0.size() != 0) begin
            failures++;
            $display("FAIL grant_writes: %0d writes pending=%0d, expected 3 0",
                     wr_seen[0], exp_wr0.size());
        end
        clear_queues();
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        Reset    = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        grant[0] = 1'b1;
        grant[1] = 1'b1;
        bc[0]    = 0;
        bc[1]    = 0;
        for (int k = 0; k < 3; k++) begin
            py[k] = 16'h0000;
            pu[k] = 16'h0000;
            pv[k] = 16'h0000;
        end
        clear_counters();
        test_reset();
        test_black();
        test_white();
        test_three_pairs();
        test_start_ignored();
        test_reset_mid_wr();
`ifdef CSC_SRAM_GRANT_EN
        test_grant();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
